seg7_multi_display: RTL and testbench
=====================================

SEG7_MULTI_DISPLAY -- requirements
Module: seg7_multi_display

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of the input value (4..32).
REQ-002 Parameter: DIGITS, default 4, number of multiplexed digits (1..8).
REQ-003 Parameter: SCAN_DIV, default 20000, clk cycles per digit slot (1 kHz digit rate at 20 MHz); minimum 2.
REQ-004 Parameter: ACTIVE_LOW, default 1; when 1, seg7 and select are driven active-low.
REQ-005 Port: clk  input  1  system clock, single clock domain, rising-edge.
REQ-006 Port: rst_n  input  1  asynchronous active-low reset.
REQ-007 Port: number  input  WIDTH  unsigned value to display.
REQ-008 Port: load  input  1  single-cycle strobe capturing number and dec_mode.
REQ-009 Port: dec_mode  input  1  1 = decimal, 0 = hexadecimal.
REQ-010 Port: seg7  output  7  segment drive {g,f,e,d,c,b,a}.
REQ-011 Port: select  output  DIGITS  one-hot digit enable; bit 0 is the least significant digit.
REQ-012 Port: busy  output  1  high while a decimal conversion is in progress.

Function
REQ-013 In IDLE, load=1 SHALL capture number and dec_mode on that clk edge; load while busy=1 SHALL be ignored.
REQ-014 Hex load SHALL update the digit register on the capture edge itself; the new digits SHALL be visible from the next cycle; busy SHALL stay 0.
REQ-015 Decimal load SHALL enter CONVERT: shift-add-3 binary-to-BCD, one bit per cycle, exactly WIDTH cycles, with busy=1 for those WIDTH cycles starting the cycle after load.
REQ-016 The digit register SHALL update atomically on the last CONVERT edge; FSM returns to IDLE, busy=0 the following cycle; the old value stays displayed throughout conversion.
REQ-017 FSM states: IDLE, CONVERT only; CONVERT->IDLE when the bit counter reaches WIDTH-1.
REQ-018 Overflow: if the value needs more than DIGITS digits in the selected radix, every digit SHALL display a dash (segment g only).
REQ-019 Scan counter SHALL count 0..SCAN_DIV-1; on terminal count the digit index SHALL advance, wrapping DIGITS-1 -> 0.
REQ-020 select SHALL have exactly one bit active (the current index) at all times outside reset; seg7 SHALL show that digit's glyph in the same cycle.
REQ-021 Glyphs: standard 0-9, A, b, C, d, E, F; dash = g only; blank = all segments off.
REQ-022 load/capture SHALL NOT disturb the scan counter or digit index.

Reset
REQ-023 While rst_n=0: FSM=IDLE, busy=0, scan counter=0, index=0, digit register = value 0.
REQ-024 While rst_n=0, seg7 and select SHALL be inactive (all off per ACTIVE_LOW).
REQ-025 Reset during CONVERT SHALL abort the conversion; display SHALL come up showing 0 on digit 0 after release.
REQ-026 First scan output SHALL appear the first clk edge after rst_n deasserts, on digit 0.

Configuration
REQ-027 Macro SEG7_LZ_BLANK_EN: when defined, leading-zero digits above the most significant nonzero digit SHALL be blanked; digit 0 SHALL never be blanked.
REQ-028 Without SEG7_LZ_BLANK_EN, all DIGITS digits SHALL always be displayed, including leading zeros.
REQ-029 Overflow dashes (REQ-018) SHALL be unaffected by the macro.

Verification
REQ-030 Defaults, hex load number=8'hA7 -> digits 0..3 = 7, A, 0, 0 (blank, blank with macro); busy never high.
REQ-031 Decimal load 8'd255 -> busy high exactly 8 cycles; then digits = 5, 5, 2, 0; old value held until update.
REQ-032 DIGITS=2, decimal load 8'd100 -> both digits show dash; same value in hex -> 4, 6.
REQ-033 SCAN_DIV=4 -> select steps 0001, 0010, 0100, 1000, 0001 every 4 cycles; exactly one bit active; ACTIVE_LOW=1 inverts.
REQ-034 Second load during busy -> ignored; result equals first value.
REQ-035 Reset asserted mid-CONVERT -> busy=0, outputs off; after release digit 0 shows 0.

Source files
------------

// File: rtl/seg7_multi_display.sv
// Multiplexed 7-segment driver: hex or decimal (shift-add-3) display of a captured value.
// Optional build macro SEG7_LZ_BLANK_EN blanks leading-zero digits above the top nonzero digit.
module seg7_multi_display #(
  parameter int WIDTH      = 8,
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 20000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  number,
  input  logic              load,
  input  logic              dec_mode,
  output logic [6:0]        seg7,
  output logic [DIGITS-1:0] select,
  output logic              busy
);

  // (WIDTH+2)/3 BCD digits always suffice since 8^k < 10^k
  localparam int NBCD = (WIDTH + 2) / 3;
  localparam int BW   = 4 * NBCD;
  localparam int CW   = $clog2(SCAN_DIV);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int KW   = $clog2(WIDTH);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t                   state_q, state_d;
  logic [WIDTH-1:0]         bin_q, bin_d;
  logic [BW-1:0]            bcd_q, bcd_d, bcd_step;
  logic [KW-1:0]            bit_q, bit_d;
  logic [DIGITS-1:0][3:0]   dig_q, dig_d;
  logic                     ovf_q, ovf_d;
  logic [CW-1:0]            scan_q, scan_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     en_q;
  logic                     last_bit;

  logic [63:0]              num_ext, bcd_ext;
  logic [DIGITS-1:0][3:0]   hex_dig, dec_dig;
  logic                     hex_ovf, dec_ovf;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  // One shift-add-3 step: correct digits >= 5, then shift in the next binary MSB
  always_comb begin
    logic [BW-1:0] adj;
    adj = bcd_q;
    for (int i = 0; i < NBCD; i++)
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    bcd_step = {adj[BW-2:0], bin_q[WIDTH-1]};
  end

  always_comb begin
    num_ext = 64'(number);
    bcd_ext = 64'(bcd_step);
    for (int i = 0; i < DIGITS; i++) begin
      hex_dig[i] = num_ext[4*i +: 4];
      dec_dig[i] = bcd_ext[4*i +: 4];
    end
    hex_ovf = |(num_ext >> (4 * DIGITS));
    dec_ovf = |(bcd_ext >> (4 * DIGITS));
  end

  assign last_bit = (bit_q == KW'(WIDTH - 1));

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load && dec_mode) state_d = CONVERT;
      CONVERT: if (last_bit)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb busy = (state_q == CONVERT);

  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    bit_d = bit_q;
    dig_d = dig_q;
    ovf_d = ovf_q;
    if (state_q == IDLE) begin
      if (load) begin
        bin_d = number;
        bcd_d = '0;
        bit_d = '0;
        if (!dec_mode) begin
          dig_d = hex_dig;
          ovf_d = hex_ovf;
        end
      end
    end else begin
      bin_d = bin_q << 1;
      bcd_d = bcd_step;
      bit_d = bit_q + 1'b1;
      if (last_bit) begin
        dig_d = dec_dig;
        ovf_d = dec_ovf;
      end
    end
  end

  // Scan holds until the first edge after reset so every slot is SCAN_DIV cycles long
  always_comb begin
    scan_d = scan_q;
    idx_d  = idx_q;
    if (en_q) begin
      if (scan_q == CW'(SCAN_DIV - 1)) begin
        scan_d = '0;
        idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        scan_d = scan_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      bit_q  <= '0;
      dig_q  <= '0;
      ovf_q  <= 1'b0;
      scan_q <= '0;
      idx_q  <= '0;
      en_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      bit_q  <= bit_d;
      dig_q  <= dig_d;
      ovf_q  <= ovf_d;
      scan_q <= scan_d;
      idx_q  <= idx_d;
      en_q   <= 1'b1;
    end
  end

  always_comb begin
    logic [3:0]        cur;
    logic              blank;
    logic [6:0]        seg_act;
    logic [DIGITS-1:0] sel_act;
    cur     = '0;
    blank   = 1'b0;
    sel_act = '0;
    for (int i = 0; i < DIGITS; i++) begin
      sel_act[i] = (idx_q == IW'(i));
      if (idx_q == IW'(i)) cur = dig_q[i];
    end
`ifdef SEG7_LZ_BLANK_EN
    for (int i = 1; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        blank = 1'b1;
        for (int j = i; j < DIGITS; j++)
          if (dig_q[j] != 4'h0) blank = 1'b0;
      end
    end
`else
    blank = 1'b0;
`endif
    if (ovf_q)      seg_act = 7'h40;
    else if (blank) seg_act = 7'h00;
    else            seg_act = glyph(cur);
    if (!en_q) begin
      seg_act = '0;
      sel_act = '0;
    end
    seg7   = (ACTIVE_LOW != 0) ? ~seg_act : seg_act;
    select = (ACTIVE_LOW != 0) ? ~sel_act : sel_act;
  end

endmodule

// File: tb/tb_seg7_multi_display.sv
// Bench for seg7_multi_display: two instances (4 and 2 digits) driven from one stimulus,
// checked each cycle against an arithmetic model of value, radix, scan slot and busy window.
module tb_seg7_multi_display;

  localparam int W   = 8;
  localparam int D1  = 4;
  localparam int S1  = 4;
  localparam int D2  = 2;
  localparam int S2  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  number = '0;
  logic          load = 1'b0;
  logic          dec_mode = 1'b0;
  logic [6:0]    seg1, seg2;
  logic [D1-1:0] sel1;
  logic [D2-1:0] sel2;
  logic          busy1, busy2;

  int checks = 0;
  int failures = 0;

  // model state
  int ncyc;
  int disp_val = 0;
  bit disp_dec = 1'b0;
  int pend_val = 0;
  int busy_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) ncyc <= 0;
    else        ncyc <= ncyc + 1;

  seg7_multi_display #(.WIDTH(W), .DIGITS(D1), .SCAN_DIV(S1), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .number(number), .load(load), .dec_mode(dec_mode),
    .seg7(seg1), .select(sel1), .busy(busy1));

  seg7_multi_display #(.WIDTH(W), .DIGITS(D2), .SCAN_DIV(S2), .ACTIVE_LOW(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .number(number), .load(load), .dec_mode(dec_mode),
    .seg7(seg2), .select(sel2), .busy(busy2));

  function automatic logic [6:0] tbl(input int d);
    logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[d];
  endfunction

  function automatic logic [6:0] exp_glyph(input int val, input bit dec, input int nd, input int i);
    longint r, p, q;
    r = dec ? 10 : 16;
    p = 1;
    for (int k = 0; k < nd; k++) p = p * r;
    if (val >= p) return 7'h40;
    q = 1;
    for (int k = 0; k < i; k++) q = q * r;
`ifdef SEG7_LZ_BLANK_EN
    if (i > 0 && val < q) return 7'h00;
`endif
    return tbl(int'((val / q) % r));
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_one(input string tag, input logic [6:0] seg, input logic [7:0] sel,
                           input logic bsy, input int nd, input int sd);
    logic [7:0] mask, esel;
    logic [6:0] eseg;
    int idx;
    mask = 8'hFF >> (8 - nd);
    if (!rst_n || ncyc == 0) begin
      esel = mask;
      eseg = 7'h7F;
      chk({tag, "_busy"}, {7'b0, bsy}, 8'h00);
    end else begin
      idx  = ((ncyc - 1) / sd) % nd;
      esel = mask & ~(8'd1 << idx);
      eseg = ~exp_glyph(disp_val, disp_dec, nd, idx);
      chk({tag, "_busy"}, {7'b0, bsy}, {7'b0, busy_cnt > 0});
    end
    chk({tag, "_sel"}, sel, esel);
    chk({tag, "_seg"}, {1'b0, seg}, {1'b0, eseg});
  endtask

  task automatic check_all();
    check_one("d4", seg1, {4'b0, sel1}, busy1, D1, S1);
    check_one("d2", seg2, {6'b0, sel2}, busy2, D2, S2);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          disp_val = pend_val;
          disp_dec = 1'b1;
        end
      end else if (load) begin
        if (dec_mode) begin
          pend_val = int'(number);
          busy_cnt = W;
        end else begin
          disp_val = int'(number);
          disp_dec = 1'b0;
        end
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_load(input int v, input bit dec);
    number   = W'(v);
    dec_mode = dec;
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    disp_val = 0;
    disp_dec = 1'b0;
    busy_cnt = 0;
    #1;
    check_all();
    ticks(n);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset(3);
    ticks(20);                 // zero on every digit, scan order
    do_load(8'hA7, 1'b0);      // hex: 7,A,0,0 / 7,A
    ticks(20);
    do_load(255, 1'b1);        // decimal: 8 busy cycles, then 5,5,2,0 / dashes
    ticks(24);
    do_load(100, 1'b1);        // 2-digit overflow
    ticks(20);
    do_load(100, 1'b0);        // 0x64 -> 4,6
    ticks(20);
    do_load(42, 1'b1);         // second load during busy is ignored
    ticks(2);
    do_load(99, 1'b1);
    do_load(17, 1'b0);
    ticks(20);
    for (int n = 0; n < 30; n++) begin
      do_load(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      ticks(int'($urandom_range(1, 12)));
    end
    ticks(16);
    do_load(200, 1'b1);        // reset mid-conversion
    ticks(3);
    do_reset(2);
    ticks(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
